// File: rtl/dma_reader_2d.sv
// AXI4 2D read DMA: fetches rows of words at a fixed stride and streams them with
// end-of-line / end-of-frame flags through an output FIFO.
module dma_reader_2d #(
  parameter int DataBits   = 64,
  parameter int AddrBits   = 32,
  parameter int LengthBits = 16,
  parameter int RowBits    = 12,
  parameter int BurstSize  = 16,
  parameter int FifoDepth  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [AddrBits-1:0]   cfg_addr,
  input  logic [LengthBits-1:0] cfg_row_len,
  input  logic [RowBits-1:0]    cfg_rows,
  input  logic [AddrBits-1:0]   cfg_stride,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DataBits-1:0]   dout_data,
  output logic                  dout_eol,
  output logic                  dout_eof,
  output logic                  mst_arvalid,
  input  logic                  mst_arready,
  output logic [AddrBits-1:0]   mst_araddr,
  output logic [7:0]            mst_arlen,
  output logic [2:0]            mst_arsize,
  output logic [1:0]            mst_arburst,
  output logic [3:0]            mst_arid,
  input  logic                  mst_rvalid,
  output logic                  mst_rready,
  input  logic [DataBits-1:0]   mst_rdata,
  input  logic [1:0]            mst_rresp,
  input  logic                  mst_rlast,
  output logic                  done,
  output logic [1:0]            error,
  output logic                  busy
);

  localparam int ByteShift = $clog2(DataBits / 8);
  localparam int PtrBits   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntBits   = $clog2(FifoDepth + 1);
  localparam int BurstBits = 9;
  localparam int FifoW     = DataBits + 2;
  localparam logic [AddrBits-1:0] AlignMask = {AddrBits{1'b1}} << ByteShift;

  typedef enum logic [2:0] {
    S_IDLE, S_ROW_START, S_PREP, S_ISSUE, S_DRAIN, S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [AddrBits-1:0]   cur_q, cur_d, addr_q, addr_d, stride_q, stride_d;
  logic [LengthBits-1:0] row_len_q, row_len_d, remain_q, remain_d, rx_col_q;
  logic [RowBits-1:0]    rows_q, rows_d, iss_row_q, iss_row_d, rx_row_q;
  logic [BurstBits-1:0]  burst_q, burst_d, burst_calc;
  logic [CntBits-1:0]    pending_q, pending_d, count_q;
  logic [PtrBits-1:0]    wr_ptr_q, rd_ptr_q;
  logic [1:0]            error_q;
  logic [FifoW-1:0]      mem_q [FifoDepth];
  logic [12:0]           to_4k, words_4k;
  logic [31:0]           burst_lim, pend_sum;
  logic                  accept, ar_hs, r_hs, pop, space_ok, rx_eol, rx_eof;
  logic                  unused_rlast;

  assign unused_rlast = mst_rlast;

  assign cfg_ready   = (state_q == S_IDLE) && !rst;
  assign accept      = cfg_valid && cfg_ready;
  assign busy        = (state_q != S_IDLE);
  assign error       = error_q;
  assign mst_araddr  = addr_q;
  assign mst_arlen   = 8'(burst_q - BurstBits'(1));
  assign mst_arsize  = 3'(ByteShift);
  assign mst_arburst = 2'b01;
  assign mst_arid    = 4'd0;

  // pending + used only shrinks while waiting, so arvalid stays up once raised.
  assign space_ok    = (32'(pending_q) + 32'(burst_q)) <= (32'(FifoDepth) - 32'(count_q));
  assign mst_arvalid = (state_q == S_ISSUE) && space_ok;
  assign ar_hs       = mst_arvalid && mst_arready;

  assign mst_rready  = (count_q != CntBits'(FifoDepth));
  assign r_hs        = mst_rvalid && mst_rready;
  assign dout_valid  = (count_q != '0);
  assign pop         = dout_valid && dout_ready;
  assign {dout_eof, dout_eol, dout_data} = mem_q[rd_ptr_q];

  assign rx_eol = (rx_col_q == row_len_q - LengthBits'(1));
  assign rx_eof = rx_eol && (rx_row_q == rows_q - RowBits'(1));

  // Burst = min(remaining row words, BurstSize, words left before the 4 KB boundary).
  always_comb begin
    to_4k     = 13'h1000 - {1'b0, addr_q[11:0]};
    words_4k  = to_4k >> ByteShift;
    burst_lim = 32'(BurstSize);
    if (32'(remain_q) < burst_lim) burst_lim = 32'(remain_q);
    if (32'(words_4k) < burst_lim) burst_lim = 32'(words_4k);
    burst_calc = BurstBits'(burst_lim);
  end

  always_comb begin
    pend_sum = 32'(pending_q) + (ar_hs ? 32'(burst_q) : 32'd0);
    if (r_hs && pend_sum != 32'd0) pend_sum = pend_sum - 32'd1;
    pending_d = CntBits'(pend_sum);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d   = state_q;
    cur_d     = cur_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    row_len_d = row_len_q;
    rows_d    = rows_q;
    remain_d  = remain_q;
    burst_d   = burst_q;
    iss_row_d = iss_row_q;
    done      = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        cur_d     = cfg_addr & AlignMask;
        stride_d  = cfg_stride & AlignMask;
        row_len_d = cfg_row_len;
        rows_d    = cfg_rows;
        iss_row_d = '0;
        state_d   = (cfg_row_len == '0 || cfg_rows == '0) ? S_FINISH : S_ROW_START;
      end
      S_ROW_START: begin
        addr_d   = cur_q;
        remain_d = row_len_q;
        state_d  = S_PREP;
      end
      S_PREP: begin
        burst_d = burst_calc;
        state_d = S_ISSUE;
      end
      S_ISSUE: if (ar_hs) begin
        remain_d = remain_q - LengthBits'(burst_q);
        addr_d   = addr_q + (AddrBits'(burst_q) << ByteShift);
        if (remain_d != '0) begin
          state_d = S_PREP;
        end else if (iss_row_q != rows_q - RowBits'(1)) begin
          iss_row_d = iss_row_q + RowBits'(1);
          cur_d     = cur_q + stride_q;
          state_d   = S_ROW_START;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (pop && dout_eof) begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      addr_q    <= '0;
      stride_q  <= '0;
      row_len_q <= '0;
      rows_q    <= '0;
      remain_q  <= '0;
      burst_q   <= '0;
      iss_row_q <= '0;
      pending_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rx_col_q  <= '0;
      rx_row_q  <= '0;
      error_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      row_len_q <= row_len_d;
      rows_q    <= rows_d;
      remain_q  <= remain_d;
      burst_q   <= burst_d;
      iss_row_q <= iss_row_d;
      pending_q <= pending_d;
      if (r_hs) wr_ptr_q <= (wr_ptr_q == PtrBits'(FifoDepth - 1)) ? '0 : wr_ptr_q + PtrBits'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrBits'(FifoDepth - 1)) ? '0 : rd_ptr_q + PtrBits'(1);
      case ({r_hs, pop})
        2'b10:   count_q <= count_q + CntBits'(1);
        2'b01:   count_q <= count_q - CntBits'(1);
        default: count_q <= count_q;
      endcase
      if (accept) begin
        error_q  <= '0;
        rx_col_q <= '0;
        rx_row_q <= '0;
      end else if (r_hs) begin
        if (error_q == 2'b00) error_q <= mst_rresp;
        if (rx_eol) begin
          rx_col_q <= '0;
          rx_row_q <= rx_row_q + RowBits'(1);
        end else begin
          rx_col_q <= rx_col_q + LengthBits'(1);
        end
      end
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (r_hs) mem_q[wr_ptr_q] <= {rx_eof, rx_eol, mst_rdata};
  end

endmodule

// File: tb/tb_dma_reader_2d.sv
// Bench for dma_reader_2d: AXI read slave with a memory function, frame-level
// reference model of expected bursts and output words, and directed corner frames.
module tb_dma_reader_2d;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int RW = 12;
  localparam int BS = 16;
  localparam int FD = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready;
  logic [AW-1:0] cfg_addr, cfg_stride;
  logic [LW-1:0] cfg_row_len;
  logic [RW-1:0] cfg_rows;
  logic          dout_valid, dout_ready, dout_eol, dout_eof;
  logic [DW-1:0] dout_data;
  logic          mst_arvalid, mst_arready;
  logic [AW-1:0] mst_araddr;
  logic [7:0]    mst_arlen;
  logic [2:0]    mst_arsize;
  logic [1:0]    mst_arburst;
  logic [3:0]    mst_arid;
  logic          mst_rvalid, mst_rready, mst_rlast;
  logic [DW-1:0] mst_rdata;
  logic [1:0]    mst_rresp;
  logic          done, busy;
  logic [1:0]    error;

  always #5 clk = ~clk;

  dma_reader_2d #(
    .DataBits(DW), .AddrBits(AW), .LengthBits(LW), .RowBits(RW),
    .BurstSize(BS), .FifoDepth(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_row_len(cfg_row_len), .cfg_rows(cfg_rows), .cfg_stride(cfg_stride),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_eol(dout_eol), .dout_eof(dout_eof),
    .mst_arvalid(mst_arvalid), .mst_arready(mst_arready), .mst_araddr(mst_araddr),
    .mst_arlen(mst_arlen), .mst_arsize(mst_arsize), .mst_arburst(mst_arburst),
    .mst_arid(mst_arid),
    .mst_rvalid(mst_rvalid), .mst_rready(mst_rready), .mst_rdata(mst_rdata),
    .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
    .done(done), .error(error), .busy(busy)
  );

  typedef struct { logic [63:0] data; logic eol; logic eof; } word_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [31:0] addr; logic last; } beat_t;

  word_t       exp_out[$];
  ar_t         exp_ar[$];
  beat_t       beat_q[$];
  logic [31:0] ar_log_addr[$];
  int          ar_log_len[$];

  int          total = 0;
  int          bad = 0;
  logic [31:0] salt;
  int          err_beat_a, err_beat_b, frame_beat;
  int          rdy_mode, ar_rand, r_rand;
  int          out_cnt, eol_cnt, eof_idx, done_cnt;
  int          req_words, rcv_words, pop_words;
  logic [1:0]  exp_err;
  logic        busy_m, zero_due;

  function automatic logic [63:0] mem_word(logic [31:0] a);
    return {a ^ 32'h5A5A_1234, ~a + salt};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic oops(string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event", name);
  endtask

  // AXI read slave: queues beats per accepted AR, returns them in order.
  initial begin : slave
    bit    s_ar, s_r, s_rst;
    beat_t b;
    mst_arready = 1'b0;
    mst_rvalid  = 1'b0;
    mst_rdata   = '0;
    mst_rresp   = 2'b00;
    mst_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_ar  = mst_arvalid && mst_arready && !rst;
      s_r   = mst_rvalid && mst_rready && !rst;
      if (s_ar)
        for (int i = 0; i <= int'(mst_arlen); i++)
          beat_q.push_back('{addr: mst_araddr + 32'(i) * 32'd8, last: (i == int'(mst_arlen))});
      @(posedge clk);
      #1;
      if (s_rst) begin
        beat_q.delete();
        mst_rvalid  = 1'b0;
        mst_arready = 1'b0;
      end else begin
        if (s_r) mst_rvalid = 1'b0;
        if (!mst_rvalid && beat_q.size() > 0 && (r_rand == 0 || $urandom_range(0, 99) < 60)) begin
          b          = beat_q.pop_front();
          mst_rvalid = 1'b1;
          mst_rdata  = mem_word(b.addr);
          mst_rlast  = b.last;
          mst_rresp  = (frame_beat == err_beat_a) ? 2'd2 : (frame_beat == err_beat_b) ? 2'd3 : 2'd0;
          frame_beat++;
        end
        mst_arready = (ar_rand == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : ready_drv
    dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       dout_ready = 1'b0;
        1:       dout_ready = 1'b1;
        default: dout_ready = ($urandom_range(0, 99) < 70);
      endcase
    end
  end

  // Compare process: every handshake and status output against the frame model.
  bit    m_pop, m_arf, m_rf, m_acc, m_exp_done;
  word_t m_w;
  ar_t   m_a;
  always @(negedge clk) begin
    if (rst) begin
      busy_m   = 1'b0;
      zero_due = 1'b0;
      exp_err  = 2'b00;
    end else begin
      m_pop = dout_valid && dout_ready;
      m_arf = mst_arvalid && mst_arready;
      m_rf  = mst_rvalid && mst_rready;
      m_acc = cfg_valid && cfg_ready;
      check("error", 64'(error), 64'(exp_err));
      check("busy", 64'(busy), 64'(busy_m));
      check("cfg_ready", 64'(cfg_ready), 64'(!busy_m));
      m_exp_done = zero_due || (m_pop && exp_out.size() > 0 && exp_out[0].eof);
      if (done || m_exp_done) check("done", 64'(done), 64'(m_exp_done));
      if (done) done_cnt++;
      if (m_pop) begin
        pop_words++;
        if (exp_out.size() == 0) oops("extra_word");
        else begin
          m_w = exp_out.pop_front();
          check("dout_data", dout_data, m_w.data);
          check("dout_eol", 64'(dout_eol), 64'(m_w.eol));
          check("dout_eof", 64'(dout_eof), 64'(m_w.eof));
          out_cnt++;
          if (dout_eol) eol_cnt++;
          if (dout_eof) eof_idx = out_cnt;
        end
      end
      if (m_arf) begin
        ar_log_addr.push_back(mst_araddr);
        ar_log_len.push_back(int'(mst_arlen));
        if (exp_ar.size() == 0) oops("extra_ar");
        else begin
          m_a = exp_ar.pop_front();
          check("araddr", 64'(mst_araddr), 64'(m_a.addr));
          check("arlen", 64'(mst_arlen), 64'(m_a.len));
        end
        check("arsize", 64'(mst_arsize), 64'd3);
        check("arburst", 64'(mst_arburst), 64'd1);
        check("arid", 64'(mst_arid), 64'd0);
        req_words += int'(mst_arlen) + 1;
        check("pending_bound", 64'((req_words - rcv_words) <= FD), 64'd1);
        check("inflight_bound", 64'((req_words - pop_words) <= FD), 64'd1);
      end
      if (m_rf) begin
        rcv_words++;
        if (mst_rresp != 2'b00 && exp_err == 2'b00) exp_err = mst_rresp;
      end
      if (done) busy_m = 1'b0;
      if (m_acc) begin
        busy_m  = 1'b1;
        exp_err = 2'b00;
      end
      zero_due = m_acc && (cfg_rows == '0 || cfg_row_len == '0);
    end
  end

  // Model: row r starts at base + r*stride; bursts split at row end, BS and 4 KB.
  task automatic start_frame(logic [31:0] a, int len, int rows, logic [31:0] stride);
    logic [31:0] ra, ba;
    int rem, b, to, n;
    salt = $urandom;
    a      = a & 32'hFFFF_FFF8;
    stride = stride & 32'hFFFF_FFF8;
    if (len > 0) begin
      for (int r = 0; r < rows; r++) begin
        ra = a + 32'(r) * stride;
        for (int c = 0; c < len; c++)
          exp_out.push_back('{data: mem_word(ra + 32'(c) * 32'd8),
                              eol: (c == len - 1), eof: (c == len - 1) && (r == rows - 1)});
        ba  = ra;
        rem = len;
        while (rem > 0) begin
          b  = (rem > BS) ? BS : rem;
          to = (4096 - int'(ba & 32'hFFF)) / 8;
          if (b > to) b = to;
          exp_ar.push_back('{addr: ba, len: 8'(b - 1)});
          ba  = ba + 32'(b) * 32'd8;
          rem = rem - b;
        end
      end
    end
    ar_log_addr.delete();
    ar_log_len.delete();
    out_cnt = 0; eol_cnt = 0; eof_idx = 0; done_cnt = 0; frame_beat = 0;
    @(posedge clk);
    #1;
    cfg_addr = a; cfg_row_len = LW'(len); cfg_rows = RW'(rows); cfg_stride = stride;
    cfg_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_ready && n < 200);
    if (!cfg_ready) oops("cfg_accept_timeout");
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) oops("done_timeout");
    repeat (3) @(posedge clk);
    check("out_left", 64'(exp_out.size()), 64'd0);
    check("ar_left", 64'(exp_ar.size()), 64'd0);
  endtask

  initial begin : main
    cfg_valid = 1'b0; cfg_addr = '0; cfg_row_len = '0; cfg_rows = '0; cfg_stride = '0;
    rst = 1'b1; rdy_mode = 1; ar_rand = 0; r_rand = 0;
    err_beat_a = -1; err_beat_b = -1; salt = '0; frame_beat = 0;
    out_cnt = 0; eol_cnt = 0; eof_idx = 0; done_cnt = 0;
    req_words = 0; rcv_words = 0; pop_words = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    check("rst_arvalid", 64'(mst_arvalid), 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_cfg_ready", 64'(cfg_ready), 64'd1);

    // Three short rows, one burst each.
    start_frame(32'h1000, 4, 3, 32'h100);
    wait_done(2000);
    check("t1_ar_count", 64'(ar_log_addr.size()), 64'd3);
    if (ar_log_addr.size() == 3) begin
      check("t1_ar0", 64'(ar_log_addr[0]), 64'h1000);
      check("t1_ar1", 64'(ar_log_addr[1]), 64'h1100);
      check("t1_ar2", 64'(ar_log_addr[2]), 64'h1200);
      check("t1_len0", 64'(ar_log_len[0]), 64'd3);
      check("t1_len2", 64'(ar_log_len[2]), 64'd3);
    end
    check("t1_words", 64'(out_cnt), 64'd12);
    check("t1_eols", 64'(eol_cnt), 64'd3);
    check("t1_eof_idx", 64'(eof_idx), 64'd12);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);

    // 4 KB boundary split.
    start_frame(32'h0FC0, 40, 1, 32'h0);
    wait_done(2000);
    check("t2_ar_count", 64'(ar_log_addr.size()), 64'd3);
    if (ar_log_addr.size() == 3) begin
      check("t2_ar0", 64'(ar_log_addr[0]), 64'h0FC0);
      check("t2_ar1", 64'(ar_log_addr[1]), 64'h1000);
      check("t2_ar2", 64'(ar_log_addr[2]), 64'h1080);
      check("t2_len0", 64'(ar_log_len[0]), 64'd7);
      check("t2_len1", 64'(ar_log_len[1]), 64'd15);
      check("t2_len2", 64'(ar_log_len[2]), 64'd15);
    end

    // FIFO flow control with the output stalled.
    rdy_mode = 0;
    start_frame(32'h2000, 64, 1, 32'h0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("t3_ar_count_stalled", 64'(ar_log_addr.size()), 64'd2);
    check("t3_rready_full", 64'(mst_rready), 64'd0);
    check("t3_dout_valid", 64'(dout_valid), 64'd1);
    rdy_mode = 1;
    wait_done(2000);
    check("t3_words", 64'(out_cnt), 64'd64);

    // Sticky first error, cleared by the next descriptor.
    err_beat_a = 4; err_beat_b = 8;
    start_frame(32'h3000, 16, 1, 32'h0);
    wait_done(2000);
    @(negedge clk);
    check("t4_error_sticky", 64'(error), 64'd2);
    err_beat_a = -1; err_beat_b = -1;
    start_frame(32'h3100, 4, 1, 32'h0);
    @(negedge clk);
    check("t4_error_cleared", 64'(error), 64'd0);
    wait_done(2000);

    // Empty frames: no AR, done one cycle after accept.
    start_frame(32'h4000, 8, 0, 32'h100);
    @(negedge clk);
    check("t5_rows0_done", 64'(done), 64'd1);
    @(negedge clk);
    check("t5_rows0_done_low", 64'(done), 64'd0);
    check("t5_rows0_ready", 64'(cfg_ready), 64'd1);
    check("t5_rows0_no_ar", 64'(ar_log_addr.size()), 64'd0);
    start_frame(32'h4000, 0, 3, 32'h100);
    @(negedge clk);
    check("t5_len0_done", 64'(done), 64'd1);
    @(negedge clk);
    check("t5_len0_ready", 64'(cfg_ready), 64'd1);
    check("t5_len0_no_ar", 64'(ar_log_addr.size()), 64'd0);

    // Reset in the middle of a frame.
    rdy_mode = 2; ar_rand = 1; r_rand = 1;
    start_frame(32'h5000, 64, 4, 32'h400);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_arvalid", 64'(mst_arvalid), 64'd0);
    check("t5_rst_dout_valid", 64'(dout_valid), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    exp_out.delete();
    exp_ar.delete();
    req_words = 0; rcv_words = 0; pop_words = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomised back-pressure frames.
    start_frame(32'h8000 + 32'($urandom_range(0, 511)) * 32'd8, 17, 5, 32'h200);
    wait_done(20000);
    check("t6_words", 64'(out_cnt), 64'd85);
    check("t6_eols", 64'(eol_cnt), 64'd5);
    check("t6_eof_idx", 64'(eof_idx), 64'd85);
    for (int k = 0; k < 3; k++) begin
      start_frame($urandom & 32'hFFFF_FFF8, $urandom_range(1, 40), $urandom_range(1, 4),
                  32'($urandom_range(0, 1023)) * 32'd8);
      wait_done(20000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
